// File: rtl/trace_drain_ctrl_if.sv
// Trace output port of trace_drain_ctrl.
//   master : drives valid/pc/wen/waddr/wdata, samples ready (the drain controller)
//   slave  : the trace consumer
// Signals:
//   valid  head entry present
//   ready  consumer accepts the head entry
//   pc     head instruction address
//   wen    4'hF when valid, else 4'h0
//   waddr  head destination register
//   wdata  head write data
interface trace_drain_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [3:0]  wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (output valid, pc, wen, waddr, wdata, input ready);
  modport slave  (input valid, pc, wen, waddr, wdata, output ready);
endinterface

// File: rtl/trace_drain_ctrl.sv
// Debug-trace drain controller. Collects up to two register-writeback commits per cycle
// from the dual-issue pipeline into a circular buffer and drains one entry per cycle to
// the trace port (valid/ready, fall-through head). Requests a pipeline stall with
// hysteresis between HiWm and LoWm and flags dropped entries with a sticky overflow.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   wb0_*_i      primary pipe commit (valid, pc, waddr, wdata); enqueued first
//   wb1_*_i      secondary pipe commit
//   trace_io     trace output port (master side)
//   stall_req_o  registered throttle request, high while in the throttle state
//   overflow_o   sticky, set when any commit was dropped for lack of space
//   occupancy_o  current entry count
//
// Optional feature: define TRACE_SKIP_R0_EN to filter commits that target r0.
module trace_drain_ctrl #(
  parameter int unsigned Depth = 32,
  parameter int unsigned HiWm  = Depth - 2,
  parameter int unsigned LoWm  = Depth / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb0_valid_i,
  input  logic [31:0]              wb0_pc_i,
  input  logic [4:0]               wb0_waddr_i,
  input  logic [31:0]              wb0_wdata_i,
  input  logic                     wb1_valid_i,
  input  logic [31:0]              wb1_pc_i,
  input  logic [4:0]               wb1_waddr_i,
  input  logic [31:0]              wb1_wdata_i,
  trace_drain_ctrl_if.master       trace_io,
  output logic                     stall_req_o,
  output logic                     overflow_o,
  output logic [$clog2(Depth):0]   occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] HiWmC  = CntW'(HiWm);
  localparam logic [CntW-1:0] LoWmC  = CntW'(LoWm);

  typedef enum logic [1:0] {StEmpty, StActive, StThrottle} state_e;

  logic [31:0] pc_mem    [Depth];
  logic [4:0]  waddr_mem [Depth];
  logic [31:0] wdata_mem [Depth];

  logic [PtrW-1:0] head_q, rear_q, rear_d, wr1_ptr;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q;
  logic            stall_q, ovf_q;

  logic       v0, v1, acc0, acc1, drop, pop;
  logic [1:0] n_acc;

  always_comb begin
`ifdef TRACE_SKIP_R0_EN
    v0 = wb0_valid_i && (wb0_waddr_i != 5'd0);
    v1 = wb1_valid_i && (wb1_waddr_i != 5'd0);
`else
    v0 = wb0_valid_i;
    v1 = wb1_valid_i;
`endif
    // Free space uses count at cycle start; a same-cycle pop is not credited.
    acc0    = v0 && (count_q != DepthC);
    acc1    = v1 && (count_q != DepthC) && !(v0 && (count_q == DepthC - CntW'(1)));
    drop    = (v0 && !acc0) || (v1 && !acc1);
    n_acc   = {1'b0, acc0} + {1'b0, acc1};
    pop     = (count_q != '0) && trace_io.ready;
    wr1_ptr = rear_q + PtrW'(acc0);
    rear_d  = rear_q + PtrW'(n_acc);
    count_d = count_q + CntW'(n_acc) - CntW'(pop);
  end

  // Buffer RAM: not reset. wb1 lands right after wb0 when both are accepted.
  always_ff @(posedge clk) begin
    if (acc0) begin
      pc_mem[rear_q]    <= wb0_pc_i;
      waddr_mem[rear_q] <= wb0_waddr_i;
      wdata_mem[rear_q] <= wb0_wdata_i;
    end
    if (acc1) begin
      pc_mem[wr1_ptr]    <= wb1_pc_i;
      waddr_mem[wr1_ptr] <= wb1_waddr_i;
      wdata_mem[wr1_ptr] <= wb1_wdata_i;
    end
  end

  // Pointers, count, overflow and the throttle FSM with its registered stall output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      rear_q  <= '0;
      count_q <= '0;
      state_q <= StEmpty;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_q + PtrW'(pop);
      rear_q  <= rear_d;
      count_q <= count_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        StEmpty: begin
          if (count_d != '0) begin
            state_q <= StActive;
          end
        end
        StActive: begin
          if (count_d >= HiWmC) begin
            state_q <= StThrottle;
            stall_q <= 1'b1;
          end else if (count_d == '0) begin
            state_q <= StEmpty;
          end
        end
        StThrottle: begin
          if (count_d == '0) begin
            state_q <= StEmpty;
            stall_q <= 1'b0;
          end else if (count_d <= LoWmC) begin
            state_q <= StActive;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StEmpty;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // Fall-through head; data is masked to zero while empty.
  always_comb begin
    trace_io.valid = (count_q != '0);
    trace_io.wen   = 4'h0;
    trace_io.pc    = '0;
    trace_io.waddr = '0;
    trace_io.wdata = '0;
    if (trace_io.valid) begin
      trace_io.wen   = 4'hF;
      trace_io.pc    = pc_mem[head_q];
      trace_io.waddr = waddr_mem[head_q];
      trace_io.wdata = wdata_mem[head_q];
    end
  end

  assign stall_req_o = stall_q;
  assign overflow_o  = ovf_q;
  assign occupancy_o = count_q;

endmodule

// File: tb/tb_trace_drain_ctrl.sv
// Self-checking bench for trace_drain_ctrl: directed vector table, hand-written corner
// sequences (watermarks, overflow, wrap, mid-stream reset, r0 filter) and randomized
// traffic checked against a queue-based reference model.
module tb_trace_drain_ctrl;
  localparam int DEPTH = 32;
  localparam int HI    = DEPTH - 2;
  localparam int LO    = DEPTH / 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef TRACE_SKIP_R0_EN
  localparam bit SkipR0 = 1'b1;
`else
  localparam bit SkipR0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb0_valid, wb1_valid;
  logic [31:0]   wb0_pc, wb0_wdata, wb1_pc, wb1_wdata;
  logic [4:0]    wb0_waddr, wb1_waddr;
  logic          stall, ovf;
  logic [CW-1:0] occ;

  trace_drain_ctrl_if trace_if_i ();

  trace_drain_ctrl #(.Depth(DEPTH), .HiWm(HI), .LoWm(LO)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb0_valid_i (wb0_valid),
    .wb0_pc_i    (wb0_pc),
    .wb0_waddr_i (wb0_waddr),
    .wb0_wdata_i (wb0_wdata),
    .wb1_valid_i (wb1_valid),
    .wb1_pc_i    (wb1_pc),
    .wb1_waddr_i (wb1_waddr),
    .wb1_wdata_i (wb1_wdata),
    .trace_io    (trace_if_i.master),
    .stall_req_o (stall),
    .overflow_o  (ovf),
    .occupancy_o (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  // Reference model state
  entry_t mq[$];
  bit     m_ovf;
  bit     m_stall;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_wb(input logic v0, input logic [31:0] pc0, input logic [4:0] a0,
                        input logic v1, input logic [31:0] pc1, input logic [4:0] a1);
    wb0_valid = v0; wb0_pc = pc0; wb0_waddr = a0; wb0_wdata = ~pc0;
    wb1_valid = v1; wb1_pc = pc1; wb1_waddr = a1; wb1_wdata = ~pc1;
  endtask

  task automatic idle_wb();
    set_wb(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0);
  endtask

  // One clock: model decides from pre-edge state, then both advance; returns #1 after edge.
  task automatic tick();
    entry_t pl[$];
    bit     pop;
    int     free;
    int     n;
    pop  = (mq.size() != 0) && trace_if_i.ready;
    free = DEPTH - mq.size();
    if (wb0_valid && !(SkipR0 && wb0_waddr == 5'd0))
      pl.push_back('{pc: wb0_pc, waddr: wb0_waddr, wdata: wb0_wdata});
    if (wb1_valid && !(SkipR0 && wb1_waddr == 5'd0))
      pl.push_back('{pc: wb1_pc, waddr: wb1_waddr, wdata: wb1_wdata});
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
    end else begin
      if (pl.size() > free) begin
        m_ovf = 1'b1;
        while (pl.size() > free) void'(pl.pop_back());
      end
      if (pop) void'(mq.pop_front());
      foreach (pl[i]) mq.push_back(pl[i]);
      n = mq.size();
      if (n == 0) m_stall = 1'b0;
      else if (n >= HI) m_stall = 1'b1;
      else if (n <= LO) m_stall = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    bit          v;
    logic [31:0] epc, edata;
    logic [4:0]  ea;
    v     = (mq.size() != 0);
    epc   = v ? mq[0].pc : 32'h0;
    ea    = v ? mq[0].waddr : 5'h0;
    edata = v ? mq[0].wdata : 32'h0;
    chk({tag, ".valid"}, trace_if_i.valid, v);
    chk({tag, ".wen"}, trace_if_i.wen, v ? 32'hF : 32'h0);
    chk({tag, ".pc"}, trace_if_i.pc, epc);
    chk({tag, ".waddr"}, trace_if_i.waddr, ea);
    chk({tag, ".wdata"}, trace_if_i.wdata, edata);
    chk({tag, ".occ"}, occ, mq.size());
    chk({tag, ".stall"}, stall, m_stall);
    chk({tag, ".ovf"}, ovf, m_ovf);
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] pc0;
    logic [4:0]  a0;
    logic        v1;
    logic [31:0] pc1;
    logic [4:0]  a1;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [4:0]  ea;
    int          eocc;
  } vec_t;

  vec_t vt[6];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int popidx;
    int guard;
    // Expected outputs are those seen one cycle after the row's inputs are applied.
    vt[0] = '{1'b1, 32'h100, 5'd3, 1'b1, 32'h104, 5'd5, 1'b0, 1'b1, 32'h100, 5'd3, 2};
    vt[1] = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   5'd0, 1'b1, 1'b1, 32'h104, 5'd5, 1};
    vt[2] = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   5'd0, 1'b1, 1'b0, 32'h0,   5'd0, 0};
    vt[3] = '{1'b0, 32'h0,   5'd0, 1'b1, 32'h200, 5'd7, 1'b1, 1'b1, 32'h200, 5'd7, 1};
    vt[4] = '{1'b1, 32'h204, 5'd8, 1'b0, 32'h0,   5'd0, 1'b1, 1'b1, 32'h204, 5'd8, 1};
    vt[5] = '{1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   5'd0, 1'b1, 1'b0, 32'h0,   5'd0, 0};

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_wb(1'($urandom), $urandom, 5'($urandom), 1'($urandom), $urandom, 5'($urandom));
      trace_if_i.ready = 1'($urandom);
      tick();
    end
    chk("rst.valid", trace_if_i.valid, 0);
    chk("rst.occ", occ, 0);
    chk("rst.stall", stall, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.wen", trace_if_i.wen, 0);
    chk("rst.pc", trace_if_i.pc, 0);
    rst = 1'b1;
    idle_wb();
    trace_if_i.ready = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      set_wb(vt[i].v0, vt[i].pc0, vt[i].a0, vt[i].v1, vt[i].pc1, vt[i].a1);
      trace_if_i.ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d.valid", i), trace_if_i.valid, vt[i].ev);
      chk($sformatf("vec%0d.pc", i), trace_if_i.pc, vt[i].epc);
      chk($sformatf("vec%0d.waddr", i), trace_if_i.waddr, vt[i].ea);
      chk($sformatf("vec%0d.wdata", i), trace_if_i.wdata, vt[i].ev ? ~vt[i].epc : 32'h0);
      chk($sformatf("vec%0d.wen", i), trace_if_i.wen, vt[i].ev ? 32'hF : 32'h0);
      chk($sformatf("vec%0d.occ", i), occ, vt[i].eocc);
    end

    // High watermark: 15 dual pushes with the consumer stalled
    trace_if_i.ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      set_wb(1'b1, 32'h4000 + 8 * i, 5'd1, 1'b1, 32'h4004 + 8 * i, 5'd2);
      tick();
      chk($sformatf("hwm%0d.occ", i), occ, 2 * i);
      chk($sformatf("hwm%0d.stall", i), stall, (i == 15) ? 1 : 0);
    end
    // Drain: stall drops on the edge where occupancy reaches LO
    idle_wb();
    trace_if_i.ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("lwm%0d.occ", k), occ, 30 - k);
      chk($sformatf("lwm%0d.stall", k), stall, (30 - k > LO) ? 1 : 0);
      check_model("lwm");
    end

    // Overflow: fill to 31, then a dual push with a pop accepts only one
    trace_if_i.ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_wb(1'b1, 32'h5000 + 8 * i, 5'd4, 1'b1, 32'h5004 + 8 * i, 5'd6);
      tick();
    end
    set_wb(1'b1, 32'h5100, 5'd4, 1'b0, 32'h0, 5'd0);
    tick();
    chk("ovf.fill_occ", occ, 31);
    chk("ovf.before", ovf, 0);
    set_wb(1'b1, 32'h5200, 5'd4, 1'b1, 32'h5204, 5'd6);
    trace_if_i.ready = 1'b1;
    tick();
    chk("ovf.occ", occ, 31);
    chk("ovf.set", ovf, 1);
    check_model("ovf");
    idle_wb();
    trace_if_i.ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("ovf.held", ovf, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ovf.rst_ovf", ovf, 0);
    chk("ovf.rst_occ", occ, 0);

    // 40 single pushes, ready toggling every 3 cycles; pointers wrap
    popidx = 0;
    for (int i = 0; i < 40; i++) begin
      set_wb(1'b1, 32'h1000 + 4 * i, 5'(i), 1'b0, 32'h0, 5'd0);
      trace_if_i.ready = ((i / 3) % 2) == 1;
      if (trace_if_i.valid && trace_if_i.ready) begin
        chk($sformatf("wrap.pop%0d", popidx), trace_if_i.pc, 32'h1000 + 4 * popidx);
        popidx++;
      end
      tick();
      check_model("wrap");
    end
    idle_wb();
    trace_if_i.ready = 1'b1;
    guard = 0;
    while (trace_if_i.valid && guard < 64) begin
      chk($sformatf("wrap.pop%0d", popidx), trace_if_i.pc, 32'h1000 + 4 * popidx);
      popidx++;
      guard++;
      tick();
    end
    chk("wrap.total", popidx, 40);

    // Mid-stream reset discards entries
    trace_if_i.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_wb(1'b1, 32'h9000 + 4 * i, 5'd9, 1'b0, 32'h0, 5'd0);
      tick();
    end
    idle_wb();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst.valid", trace_if_i.valid, 0);
    chk("mrst.occ", occ, 0);
    chk("mrst.pc", trace_if_i.pc, 0);
    set_wb(1'b1, 32'hABC0, 5'd11, 1'b0, 32'h0, 5'd0);
    tick();
    chk("mrst.first_pc", trace_if_i.pc, 32'hABC0);
    chk("mrst.first_valid", trace_if_i.valid, 1);
    idle_wb();
    trace_if_i.ready = 1'b1;
    tick();

    // r0 commit handling
    trace_if_i.ready = 1'b0;
    set_wb(1'b1, 32'h300, 5'd0, 1'b1, 32'h304, 5'd9);
    tick();
`ifdef TRACE_SKIP_R0_EN
    chk("r0.occ", occ, 1);
    chk("r0.pc", trace_if_i.pc, 32'h304);
`else
    chk("r0.occ", occ, 2);
    chk("r0.pc", trace_if_i.pc, 32'h300);
`endif
    check_model("r0");
    idle_wb();
    trace_if_i.ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int rp;
      rp = ((c / 50) % 3 == 0) ? 25 : (((c / 50) % 3 == 1) ? 90 : 50);
      set_wb($urandom_range(0, 99) < 60, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 99) < 60, $urandom, 5'($urandom_range(0, 31)));
      trace_if_i.ready = $urandom_range(0, 99) < rp;
      rst = ($urandom_range(0, 199) != 0);
      tick();
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
